// File: rtl/dec_scan_driver_if.sv
// rtl/dec_scan_driver_if.sv - Load/status/display bundle for the decimal scan driver
interface dec_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [31:0]           value;
  logic                  load;
  logic                  busy;
  logic                  ovf;
  logic [31:0]           digit;
  logic [NUM_DIGITS-1:0] an_sel;

  modport master (
    output value, load,
    input  busy, ovf, digit, an_sel
  );

  modport slave (
    input  value, load,
    output busy, ovf, digit, an_sel
  );
endinterface

// File: rtl/dec_scan_driver.sv
// rtl/dec_scan_driver.sv - Double-dabble binary-to-BCD converter with multiplexed digit scan
// Optional feature macro: LEADING_ZERO_BLANK_EN (leading zero digits above digit 0 output 10).
module dec_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic             clk,
  input  logic             rst,
  dec_scan_driver_if.slave bus
);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  function automatic logic [31:0] max_value(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) p = p * 32'd10;
    return p - 32'd1;
  endfunction

  localparam logic [31:0]           MAX_VAL = max_value(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_RST  = ~(NUM_DIGITS'(1));

  typedef enum logic {S_IDLE, S_CONV} state_e;

  state_e                state_q, state_d;
  logic                  capture, done;
  logic [31:0]           bin_q, bin_d, bin_step;
  logic [BW-1:0]         bcd_q, bcd_d, bcd_adj, bcd_step;
  logic [4:0]            cnt_q, cnt_d;
  logic [BW-1:0]         disp_q, disp_d, view;
  logic                  ovf_q, ovf_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [SW-1:0]         scan_q, scan_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            digit_q, digit_d;
  logic                  wrap;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          capture = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (cnt_q == 5'd31) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One double-dabble step: add 3 to any BCD nibble >= 5, then shift bcd:bin left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {bcd_step, bin_step} = {bcd_adj, bin_q} << 1;
  end

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    disp_d = disp_q;
    ovf_d  = ovf_q;
    if (capture) begin
      ovf_d = (bus.value > MAX_VAL);
      bin_d = ovf_d ? MAX_VAL : bus.value;
      bcd_d = '0;
      cnt_d = '0;
    end else if (state_q == S_CONV) begin
      bin_d = bin_step;
      bcd_d = bcd_step;
      cnt_d = cnt_q + 5'd1;
      if (done) disp_d = bcd_step;
    end
  end

  always_comb begin
    wrap    = (presc_q == PW'(SCAN_DIV - 1));
    presc_d = wrap ? '0 : presc_q + PW'(1);
    scan_d  = scan_q;
    if (wrap) scan_d = (scan_q == SW'(NUM_DIGITS - 1)) ? '0 : scan_q + SW'(1);
    an_d = ~(NUM_DIGITS'(1) << scan_d);
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic lead;
    view = disp_d;
    lead = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lead = lead && (disp_d[4*i +: 4] == 4'd0);
      if (lead) view[4*i +: 4] = 4'd10;
    end
  end
`else
  assign view = disp_d;
`endif

  // Digit is selected from next-state display/scan so it tracks an_sel and busy fall on the same edge.
  always_comb begin
    digit_d = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_d == SW'(i)) digit_d = view[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      presc_q <= '0;
      scan_q  <= '0;
      an_q    <= AN_RST;
      digit_q <= 4'd0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      presc_q <= presc_d;
      scan_q  <= scan_d;
      an_q    <= an_d;
      digit_q <= digit_d;
    end
  end

  assign bus.busy   = (state_q == S_CONV);
  assign bus.ovf    = ovf_q;
  assign bus.digit  = {28'd0, digit_q};
  assign bus.an_sel = an_q;
endmodule
